keys_to_note_env: RTL

//  Parametrised successor of the combinational key-to-note mapper. Debounces NUM_KEYS raw key

---
 rtl/keys_to_note_env.sv | 136 +++++++++++++
 1 files changed

// File: rtl/keys_to_note_env.sv
// Debounced key scanner, priority note select and attack/sustain/release envelope.
// Raw key edge reaches kdb after DEBOUNCE_CYC cycles, outputs one cycle later; always ready.
module keys_to_note_env #(
   parameter int NUM_KEYS     = 7,
   parameter int NOTE_W       = 4,
   parameter int VOL_W        = 8,
   parameter int DEBOUNCE_CYC = 16,
   parameter int ATTACK_STEP  = 32,
   parameter int RELEASE_STEP = 8,
   parameter int PRIO_MODE    = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keys_in,
   input  logic                tick,
   output logic [NOTE_W-1:0]   note,
   output logic [VOL_W-1:0]    volume,
   output logic [NUM_KEYS-1:0] key_array,
   output logic                note_valid,
   output logic                note_chg
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [VOL_W-1:0] VOL_MAX   = '1;
   localparam logic [VOL_W:0]   VOL_MAX_X = {1'b0, VOL_MAX};

   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

   logic [CNT_W-1:0]    cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0] kdb, kdb_d, rise, onehot;
   logic [NOTE_W-1:0]   last_key, low_held, low_rise, sel;
   logic                any_held, held_last;
   env_state_t          state, st_mid, state_nxt;
   logic [VOL_W-1:0]    volume_nxt, up_sat, dn_sat;
   logic [VOL_W:0]      up_sum, dn_sum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kdb <= '0;
         for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys_in[i] == kdb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
               kdb[i] <= ~kdb[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise     = kdb & ~kdb_d;
   assign any_held = |kdb;

   // last_key only matters when nothing newly rose; a stale value is harmless
   always_comb begin
      low_held  = '0;
      low_rise  = '0;
      held_last = 1'b0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (kdb[i])  low_held = NOTE_W'(i);
         if (rise[i]) low_rise = NOTE_W'(i);
         if (last_key == NOTE_W'(i)) held_last = kdb[i];
      end
      if (PRIO_MODE == 0)  sel = low_held;
      else if (|rise)      sel = low_rise;
      else if (held_last)  sel = last_key;
      else                 sel = low_held;
      for (int i = 0; i < NUM_KEYS; i++) onehot[i] = any_held && (sel == NOTE_W'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kdb_d      <= '0;
         note       <= '0;
         last_key   <= '0;
         key_array  <= '0;
         note_valid <= 1'b0;
         note_chg   <= 1'b0;
      end else begin
         kdb_d      <= kdb;
         key_array  <= onehot;
         note_valid <= any_held;
         note_chg   <= any_held && (!note_valid || (sel != note));
         if (any_held) begin
            note     <= sel;
            last_key <= sel;
         end
      end
   end

   assign up_sum = {1'b0, volume} + (VOL_W+1)'(ATTACK_STEP);
   assign dn_sum = {1'b0, volume} - (VOL_W+1)'(RELEASE_STEP);
   assign up_sat = (up_sum > VOL_MAX_X) ? VOL_MAX : up_sum[VOL_W-1:0];
   assign dn_sat = dn_sum[VOL_W] ? '0 : dn_sum[VOL_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         volume <= '0;
      end else begin
         state  <= state_nxt;
         volume <= volume_nxt;
      end
   end

   // key-driven transition first, then the tick step in the resulting state
   always_comb begin
      st_mid = state;
      case (state)
         IDLE:            if (any_held)  st_mid = ATTACK;
         ATTACK, SUSTAIN: if (!any_held) st_mid = RELEASE;
         RELEASE:         if (any_held)  st_mid = ATTACK;
         default:         st_mid = IDLE;
      endcase
      state_nxt  = st_mid;
      volume_nxt = volume;
      case (st_mid)
         IDLE:    volume_nxt = '0;
         ATTACK:  if (tick) begin
                     volume_nxt = up_sat;
                     if (up_sat == VOL_MAX) state_nxt = SUSTAIN;
                  end
         SUSTAIN: volume_nxt = VOL_MAX;
         RELEASE: if (tick) begin
                     volume_nxt = dn_sat;
                     if (dn_sat == '0) state_nxt = IDLE;
                  end
         default: volume_nxt = '0;
      endcase
   end

endmodule
